// File: rtl/booth_div_pkg.sv
// Shared widths, state encoding and saturation constants for the sequential
// signed divider that sits beside the Booth multiplier.
package booth_div_pkg;

    localparam int BIT  = 16;
    localparam int DW   = 2 * BIT;
    localparam int PW   = BIT + 1;
    localparam int ITER = BIT;
    localparam int CW   = $clog2(ITER);

    localparam logic [BIT-1:0] QMAX = 16'h7FFF;
    localparam logic [BIT-1:0] QMIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

endpackage

// File: rtl/div_step_17.sv
// One restoring division step on magnitudes: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step_17
    import booth_div_pkg::*;
(
    input  logic [PW-1:0]  i_part,
    input  logic           i_bit,
    input  logic [BIT-1:0] i_divisor,
    output logic [PW-1:0]  o_part,
    output logic           o_qbit
);

    logic [PW:0]   w_shift;
    logic [PW-1:0] w_trial;

    assign w_shift = {i_part, i_bit};
    // A successful subtract always leaves a value below the divisor, so the
    // truncated difference is exact whenever it is selected.
    assign o_qbit  = (w_shift >= {2'b00, i_divisor});
    assign w_trial = w_shift[PW-1:0] - {1'b0, i_divisor};
    assign o_part  = o_qbit ? w_trial : w_shift[PW-1:0];

endmodule

// File: rtl/booth_seq_divider.sv
// Iterative signed divider: 32-bit dividend by 16-bit divisor, one quotient
// bit per clock, constant latency with a start/busy/done handshake.
module booth_seq_divider
    import booth_div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [DW-1:0]  dividend,
    input  logic [BIT-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [BIT-1:0] quot,
    output logic [BIT-1:0] rem,
    output logic           div_zero,
    output logic           ovf
);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [PW-1:0]  r_part;
    logic [BIT-1:0] r_lo;
    logic [BIT-1:0] r_absD;
    logic [BIT-1:0] r_dvdLow;
    logic           r_qNeg;
    logic           r_rNeg;
    logic           r_zflag;
    logic           r_oflag;
    logic           r_busy;
    logic           r_done;
    logic [BIT-1:0] r_quot;
    logic [BIT-1:0] r_rem;
    logic           r_divZero;
    logic           r_ovf;

    logic [DW-1:0]  w_absN;
    logic [BIT-1:0] w_absD;
    logic           w_zero;
    logic           w_ovfPre;
    logic [PW-1:0]  w_partNext;
    logic           w_qbit;
    logic [BIT-1:0] w_qMag;
    logic [BIT-1:0] w_rMag;
    logic           w_ovfFix;
    logic [BIT-1:0] w_quotFix;
    logic [BIT-1:0] w_remFix;
    logic           w_dzFix;

    // Unsigned magnitudes; the most negative values map onto 2^31 and 2^15.
    assign w_absN   = dividend[DW-1] ? -dividend : dividend;
    assign w_absD   = divisor[BIT-1] ? -divisor : divisor;
    assign w_zero   = (divisor == '0);
    assign w_ovfPre = !w_zero && (w_absN[DW-1:BIT] >= w_absD);

    div_step_17 u_step (
        .i_part    (r_part),
        .i_bit     (r_lo[BIT-1]),
        .i_divisor (r_absD),
        .o_part    (w_partNext),
        .o_qbit    (w_qbit)
    );

    assign w_qMag   = r_lo;
    assign w_rMag   = r_part[BIT-1:0];
    assign w_ovfFix = r_oflag || (!r_qNeg && (w_qMag > QMAX)) || (r_qNeg && (w_qMag > QMIN));

    always_comb begin
        w_quotFix = r_qNeg ? -w_qMag : w_qMag;
        w_remFix  = r_rNeg ? -w_rMag : w_rMag;
        w_dzFix   = 1'b0;
        if (r_zflag) begin
            w_quotFix = r_rNeg ? QMIN : QMAX;
            w_remFix  = r_dvdLow;
            w_dzFix   = 1'b1;
        end else if (w_ovfFix) begin
            w_quotFix = r_qNeg ? QMIN : QMAX;
            w_remFix  = '0;
        end
    end

    // The quotient bits shift into r_lo as the dividend low half shifts out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_part    <= '0;
            r_lo      <= '0;
            r_absD    <= '0;
            r_dvdLow  <= '0;
            r_qNeg    <= 1'b0;
            r_rNeg    <= 1'b0;
            r_zflag   <= 1'b0;
            r_oflag   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divZero <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_part   <= {1'b0, w_absN[DW-1:BIT]};
                        r_lo     <= w_absN[BIT-1:0];
                        r_absD   <= w_absD;
                        r_dvdLow <= dividend[BIT-1:0];
                        r_qNeg   <= dividend[DW-1] ^ divisor[BIT-1];
                        r_rNeg   <= dividend[DW-1];
                        r_zflag  <= w_zero;
                        r_oflag  <= w_ovfPre;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_part <= w_partNext;
                    r_lo   <= {r_lo[BIT-2:0], w_qbit};
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(ITER - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_quot    <= w_quotFix;
                    r_rem     <= w_remFix;
                    r_divZero <= w_dzFix;
                    r_ovf     <= !r_zflag && w_ovfFix;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quot     = r_quot;
    assign rem      = r_rem;
    assign div_zero = r_divZero;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Randomised bench for booth_seq_divider against an arithmetic reference model
// built from signed division with truncation toward zero.
module tb_booth_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        div_zero;
    logic        ovf;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          doneEdge;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   edgeCount = 0;
    exp_t expQ[$];
    exp_t held;
    bit   holdValid = 1'b0;

    booth_seq_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount++;

    function automatic exp_t model(input logic [31:0] n, input logic [15:0] d);
        exp_t   e;
        longint ln, ld, lq, lr;
        ln = longint'($signed(n));
        ld = longint'($signed(d));
        e.doneEdge = 0;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (ld == 0) begin
            e.dz = 1'b1;
            e.q  = (ln < 0) ? 16'h8000 : 16'h7FFF;
            e.r  = n[15:0];
        end else begin
            lq = ln / ld;
            lr = ln % ld;
            if (lq > 32767 || lq < -32768) begin
                e.ov = 1'b1;
                e.q  = (lq < 0) ? 16'h8000 : 16'h7FFF;
                e.r  = 16'h0000;
            end else begin
                e.q = lq[15:0];
                e.r = lr[15:0];
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e, input bit atDone);
        check(atDone ? "quot" : "quot_hold", 32'(quot), 32'(e.q));
        check(atDone ? "rem" : "rem_hold", 32'(rem), 32'(e.r));
        check(atDone ? "div_zero" : "div_zero_hold", 32'(div_zero), 32'(e.dz));
        check(atDone ? "ovf" : "ovf_hold", 32'(ovf), 32'(e.ov));
        if (atDone) begin
            check("busy_on_done", 32'(busy), 32'd0);
            check("latency", 32'(edgeCount), 32'(e.doneEdge));
        end
    endtask

    // Single compare process: results on every done pulse, held values otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (expQ.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    held = expQ.pop_front();
                    checkOutput(held, 1'b1);
                    holdValid = 1'b1;
                end
            end else if (holdValid) begin
                checkOutput(held, 1'b0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [31:0] n, input logic [15:0] d);
        exp_t e;
        int   guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            check("idle_timeout", 32'(busy), 32'd0);
            return;
        end
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        e = model(n, d);
        e.doneEdge = edgeCount + 1 + 17;
        expQ.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((busy || expQ.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 32'(expQ.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t        m;
        exp_t        z;
        logic [31:0] n;
        logic [15:0] d;
        logic [15:0] a;
        longint      t;
        int          firstDone;
        logic [15:0] dEdge [5];
        logic [31:0] nEdge [6];

        dEdge = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
        nEdge = '{32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'hFFFF8000, 32'h00008000, 32'hFFFFFFFF};

        // Model pinned to hand-computed values.
        m = model(-32'sd7000, 16'd1000);
        check("pin_neg7000_q", 32'(m.q), 32'h0000FFF9);
        check("pin_neg7000_r", 32'(m.r), 32'h0);
        m = model(32'd12345, 16'd100);
        check("pin_12345_q", 32'(m.q), 32'd123);
        check("pin_12345_r", 32'(m.r), 32'd45);
        m = model(-32'sd12345, 16'd100);
        check("pin_n12345_q", 32'(m.q), 32'h0000FF85);
        check("pin_n12345_r", 32'(m.r), 32'h0000FFD3);
        m = model(32'd12345, -16'sd100);
        check("pin_12345_nd_q", 32'(m.q), 32'h0000FF85);
        check("pin_12345_nd_r", 32'(m.r), 32'd45);
        m = model(32'd500, 16'd0);
        check("pin_dz_q", 32'(m.q), 32'h00007FFF);
        check("pin_dz_r", 32'(m.r), 32'h000001F4);
        check("pin_dz_flag", 32'(m.dz), 32'd1);
        m = model(-32'sd500, 16'd0);
        check("pin_dzn_q", 32'(m.q), 32'h00008000);
        m = model(32'hFFFF8000, 16'd1);
        check("pin_min_q", 32'(m.q), 32'h00008000);
        check("pin_min_ovf", 32'(m.ov), 32'd0);
        m = model(32'd32768, 16'd1);
        check("pin_ovf_q", 32'(m.q), 32'h00007FFF);
        check("pin_ovf_flag", 32'(m.ov), 32'd1);
        m = model(32'h80000000, 16'hFFFF);
        check("pin_ovf2_q", 32'(m.q), 32'h00007FFF);
        check("pin_ovf2_flag", 32'(m.ov), 32'd1);
        m = model(32'd1000, 16'd10);
        check("pin_1000_q", 32'(m.q), 32'd100);

        #2 rst = 1'b1;
        #1;
        z.q = 16'h0; z.r = 16'h0; z.dz = 1'b0; z.ov = 1'b0; z.doneEdge = 0;
        checkOutput(z, 1'b0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        held = z;
        holdValid = 1'b1;
        @(negedge clk);

        // Directed vectors.
        applyStimulus(-32'sd7000, 16'd1000);
        applyStimulus(-32'sd12345, 16'd100);
        applyStimulus(32'd12345, -16'sd100);
        applyStimulus(32'd500, 16'd0);
        applyStimulus(-32'sd500, 16'd0);
        applyStimulus(32'hFFFF8000, 16'd1);
        applyStimulus(32'd32768, 16'd1);
        applyStimulus(32'h80000000, 16'hFFFF);
        waitIdle();

        // Start while busy is ignored.
        applyStimulus(32'd12345, 16'd100);
        repeat (4) @(negedge clk);
        dividend = 32'd99999;
        divisor  = 16'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle();

        // Back-to-back accept on the done cycle.
        applyStimulus(32'd40000, 16'd3);
        firstDone = expQ[0].doneEdge;
        applyStimulus(-32'sd40000, 16'd7);
        check("back_to_back_accept", 32'(edgeCount), 32'(firstDone + 1));
        waitIdle();

        // Reset mid-operation aborts without a done pulse.
        applyStimulus(32'd12345, 16'd100);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quot", 32'(quot), 32'd0);
        check("abort_rem", 32'(rem), 32'd0);
        check("abort_dz", 32'(div_zero), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        expQ.delete();
        held = z;
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        applyStimulus(32'd1000, 16'd10);
        waitIdle();

        // Random operand pairs over several distributions.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    n = $urandom;
                    d = 16'($urandom);
                end
                1: begin
                    d = 16'($urandom);
                    a = 16'($urandom);
                    t = longint'($signed(a)) * longint'($signed(d))
                        + longint'($urandom_range(0, 200)) - 100;
                    n = t[31:0];
                end
                2: begin
                    d = dEdge[$urandom_range(0, 4)];
                    n = ($urandom_range(0, 1) == 1) ? nEdge[$urandom_range(0, 5)] : $urandom;
                end
                3: begin
                    n = $urandom >> $urandom_range(8, 31);
                    if ($urandom_range(0, 1) == 1) n = -n;
                    d = 16'($urandom_range(1, 2000));
                    if ($urandom_range(0, 1) == 1) d = -d;
                end
                default: begin
                    a = 16'($urandom);
                    n = {{16{a[15]}}, a};
                    d = 16'($urandom);
                end
            endcase
            applyStimulus(n, d);
        end
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
